// File: rtl/alu_prefix_pipe.sv
// Registered ALU with a Kogge-Stone prefix adder, an accumulator and a carry flag for chaining multi-word ops.
// Latency 1 cycle; in_ready = !out_valid || out_ready, so a held result stalls the input side.
module alu_prefix_pipe #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             cin,
  input  logic             acc_mode,
  input  logic             chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [WIDTH-1:0] acc;
  logic             cflag;
  logic             accept;
  logic [WIDTH-1:0] a_eff, b_eff, p0, sum;
  logic             c_eff, add_cout;
  logic [WIDTH-1:0] gk [0:LEVELS];
  logic [WIDTH-1:0] pk [0:LEVELS];
  logic [WIDTH-1:0] r_nxt;
  logic             cout_nxt, ovf_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign a_eff    = acc_mode ? acc : a;
  assign c_eff    = chain ? cflag : cin;
  assign b_eff    = (sel == OP_SUB) ? ~b : b;

  // Carry-in is folded into bit 0's generate, so the tree needs only ceil(log2 WIDTH) levels.
  always_comb begin
    p0    = a_eff ^ b_eff;
    gk[0] = a_eff & b_eff;
    gk[0][0] = (a_eff[0] & b_eff[0]) | (p0[0] & c_eff);
    pk[0] = p0;
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << l)) begin
          gk[l+1][i] = gk[l][i] | (pk[l][i] & gk[l][i-(1<<l)]);
          pk[l+1][i] = pk[l][i] & pk[l][i-(1<<l)];
        end else begin
          gk[l+1][i] = gk[l][i];
          pk[l+1][i] = pk[l][i];
        end
      end
    end
    sum      = p0 ^ {gk[LEVELS][WIDTH-2:0], c_eff};
    add_cout = gk[LEVELS][WIDTH-1];
  end

  always_comb begin
    r_nxt    = '0;
    cout_nxt = 1'b0;
    ovf_nxt  = 1'b0;
    case (sel)
      OP_ADD, OP_SUB: begin
        r_nxt    = sum;
        cout_nxt = add_cout;
        ovf_nxt  = (a_eff[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_eff[WIDTH-1]);
      end
      OP_AND: r_nxt = a_eff & b;
      OP_OR:  r_nxt = a_eff | b;
      OP_XOR: r_nxt = a_eff ^ b;
      OP_NOT: r_nxt = ~a_eff;
      OP_SHL: begin
        r_nxt    = {a_eff[WIDTH-2:0], c_eff};
        cout_nxt = a_eff[WIDTH-1];
      end
      OP_SHR: begin
        r_nxt    = {c_eff, a_eff[WIDTH-1:1]};
        cout_nxt = a_eff[0];
      end
    endcase
  end

  // Result, flags, accumulator and carry flag move only on accept; a drain clears just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r         <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= ACC_RESET;
      cflag     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      r         <= r_nxt;
      cout      <= cout_nxt;
      zero      <= (r_nxt == '0);
      ovf       <= ovf_nxt;
      acc       <= r_nxt;
      cflag     <= cout_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
